// File: rtl/rca_alu_seq_pkg.sv
// Shared types for the wide-operand RCA_ALU sequencer.
// Opcodes, FSM states and the ALU control vector live here.
package rca_alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_RSUB  = 3'd2,
      OP_OR    = 3'd3,
      OP_FLOOD = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic inv_a;
      logic inv_b;
      logic c_in;
      logic or_en;
      logic flood;
   } alu_ctrl_t;

   // Reserved opcodes run as ADD, so only OR and FLOOD break the chain.
   function automatic logic chain_en(input op_e op);
      return !(op == OP_OR || op == OP_FLOOD);
   endfunction

endpackage

// File: rtl/rca_alu_op_decode.sv
// Opcode to word-0 ALU control vector plus carry-chain flag.
// Purely combinational.
module rca_alu_op_decode
   import rca_alu_seq_pkg::*;
(
   input  op_e       op_i,
   output alu_ctrl_t ctrl_o,
   output logic      chain_o
);

   always_comb begin
      ctrl_o  = '0;
      chain_o = chain_en(op_i);
      unique case (1'b1)
         (op_i == OP_SUB): begin
            ctrl_o.inv_b = 1'b1;
            ctrl_o.c_in  = 1'b1;
         end
         (op_i == OP_RSUB): begin
            ctrl_o.inv_a = 1'b1;
            ctrl_o.c_in  = 1'b1;
         end
         (op_i == OP_OR):    ctrl_o.or_en = 1'b1;
         (op_i == OP_FLOOD): ctrl_o.flood = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/rca_alu_sequencer.sv
// Issues a wide operation to a BitWidth-wide RCA_ALU one word per
// cycle, LSW first, chaining carry and returning result plus flags.
module rca_alu_sequencer
   import rca_alu_seq_pkg::*;
#(
   parameter int BitWidth = 4,
   parameter int Words    = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [2:0]                req_op,
   input  logic [BitWidth*Words-1:0] req_a,
   input  logic [BitWidth*Words-1:0] req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [BitWidth*Words-1:0] rsp_data,
   output logic                      rsp_cout,
   output logic                      rsp_zero,
   output logic                      rsp_overflow,
   output logic                      alu_InvA,
   output logic                      alu_InvB,
   output logic                      alu_cIn,
   output logic                      alu_ORen,
   output logic                      alu_FloodCarry,
   output logic [BitWidth-1:0]       alu_dINA,
   output logic [BitWidth-1:0]       alu_dINB,
   input  logic [BitWidth-1:0]       alu_dOUT,
   input  logic                      alu_cOut,
   input  logic                      alu_ifZero,
   input  logic                      alu_overflow
);

   localparam int W  = BitWidth * Words;
   localparam int KW = (Words > 1) ? $clog2(Words) : 1;

   state_e        state_q, state_d;
   op_e           op_q, op_d;
   logic [KW-1:0] k_q, k_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  res_q, res_d;
   logic          carry_q, carry_d;
   logic          zacc_q, zacc_d;
   logic          cout_q, cout_d;
   logic          zero_q, zero_d;
   logic          ovf_q, ovf_d;

   alu_ctrl_t base_ctrl;
   alu_ctrl_t ctrl;
   logic      chain;
   logic      last;
   int        idx;

   rca_alu_op_decode u_dec (
      .op_i   (op_q),
      .ctrl_o (base_ctrl),
      .chain_o(chain)
   );

   assign idx  = int'(k_q) * BitWidth;
   assign last = (k_q == KW'(Words - 1));

   // ALU drive is gated by state so reset silences it asynchronously.
   always_comb begin
      ctrl     = '0;
      alu_dINA = '0;
      alu_dINB = '0;
      if (state_q == RUN) begin
         ctrl = base_ctrl;
         if (k_q != '0) ctrl.c_in = chain & carry_q;
         alu_dINA = a_q[idx +: BitWidth];
         alu_dINB = b_q[idx +: BitWidth];
      end
   end

   assign alu_InvA       = ctrl.inv_a;
   assign alu_InvB       = ctrl.inv_b;
   assign alu_cIn        = ctrl.c_in;
   assign alu_ORen       = ctrl.or_en;
   assign alu_FloodCarry = ctrl.flood;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      zacc_d  = zacc_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d    = op_e'(req_op);
               a_d     = req_a;
               b_d     = req_b;
               k_d     = '0;
               zacc_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[idx +: BitWidth] = alu_dOUT;
            zacc_d  = zacc_q & alu_ifZero;
            carry_d = alu_cOut;
            if (last) begin
               cout_d  = alu_cOut;
               ovf_d   = alu_overflow;
               zero_d  = zacc_q & alu_ifZero;
               state_d = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zacc_q  <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         zacc_q  <= zacc_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == DONE);
   assign rsp_data     = res_q;
   assign rsp_cout     = cout_q;
   assign rsp_zero     = zero_q;
   assign rsp_overflow = ovf_q;

endmodule
